// File: rtl/button_conditioner_if.sv
// Pushbutton front-end bundle: raw button toward the conditioner, conditioned
// level and ticks back toward the watch FSM.
interface button_conditioner_if;
  logic button_in;
  logic level;
  logic press_tick;
  logic release_tick;
  logic repeat_tick;
  logic long_press;
  logic button_out;

  modport master (
    output button_in,
    input  level, press_tick, release_tick, repeat_tick, long_press, button_out
  );

  modport slave (
    input  button_in,
    output level, press_tick, release_tick, repeat_tick, long_press, button_out
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchroniser, debouncer and press/release/long-press/auto-repeat
// tick generator feeding the watch FSM.
module button_conditioner #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 100,
  parameter bit REPEAT_EN   = 1'b1
) (
  input logic                 clk,
  input logic                 reset_n,
  button_conditioner_if.slave bus
);

  localparam int CYC_PER_MS  = CLK_FREQ / 1000;
  localparam int DB_CYCLES   = CYC_PER_MS * DEBOUNCE_MS;
  localparam int HOLD_CYCLES = CYC_PER_MS * HOLD_MS;
  localparam int REP_CYCLES  = CYC_PER_MS * REPEAT_MS;

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int REP_W  = $clog2(REP_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    LONG,
    RELEASE_DB
  } state_e;

  logic sync_meta;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= bus.button_in;
      sync_q    <= sync_meta;
    end
  end

  state_e            state_q, state_d;
  logic              level_q, level_d;
  logic              long_q, long_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              repeat_q, repeat_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic              db_done;
  logic [HOLD_W-1:0] hold_cnt_inc;

  assign db_done      = (db_cnt_q == DB_LAST);
  assign hold_cnt_inc = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      level_q    <= 1'b0;
      long_q     <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      repeat_q   <= 1'b0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      long_q     <= long_d;
      press_q    <= press_d;
      release_q  <= release_d;
      repeat_q   <= repeat_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    long_d     = long_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    repeat_d   = 1'b0;
    db_cnt_d   = '0;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (sync_q) state_d = PRESS_DB;
      end

      PRESS_DB: begin
        if (!sync_q) begin
          state_d = IDLE;
        end else if (db_done) begin
          state_d    = HELD;
          level_d    = 1'b1;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      HELD: begin
        hold_cnt_d = hold_cnt_inc;
        // Hold completion wins over a simultaneous release edge; LONG then
        // sees the release on the following cycle.
        if (hold_cnt_q == HOLD_LAST) begin
          state_d   = LONG;
          long_d    = 1'b1;
          repeat_d  = REPEAT_EN;
          rep_cnt_d = '0;
        end else if (!sync_q) begin
          state_d = RELEASE_DB;
        end
      end

      LONG: begin
        hold_cnt_d = hold_cnt_inc;
        if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d = '0;
          repeat_d  = REPEAT_EN;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
        if (!sync_q) state_d = RELEASE_DB;
      end

      RELEASE_DB: begin
        // long_q still records which held state we left, so a bounce returns there.
        if (sync_q) begin
          state_d = long_q ? LONG : HELD;
        end else if (db_done) begin
          state_d    = IDLE;
          level_d    = 1'b0;
          release_d  = 1'b1;
          long_d     = 1'b0;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.level        = level_q;
  assign bus.press_tick   = press_q;
  assign bus.release_tick = release_q;
  assign bus.repeat_tick  = repeat_q;
  assign bus.long_press   = long_q;
  assign bus.button_out   = press_q | repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: 1 ms = 1 cycle, debounce 4, hold 20,
// repeat 5; a second instance runs with auto-repeat disabled.
module tb_button_conditioner;

  localparam int NREC = 80;
  typedef logic [NREC-1:0] trace_t;

  logic clk;
  logic reset_n;

  button_conditioner_if bus_a ();
  button_conditioner_if bus_b ();

  assign bus_b.button_in = bus_a.button_in;

  button_conditioner #(
    .CLK_FREQ(1000), .DEBOUNCE_MS(4), .HOLD_MS(20), .REPEAT_MS(5), .REPEAT_EN(1'b1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );

  button_conditioner #(
    .CLK_FREQ(1000), .DEBOUNCE_MS(4), .HOLD_MS(20), .REPEAT_MS(5), .REPEAT_EN(1'b0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic   pat [0:NREC-1];
  trace_t r_level, r_press, r_release, r_repeat, r_long, r_bout;
  trace_t b_long, b_repeat, b_bout;

  function automatic trace_t span(input int lo, input int hi);
    trace_t m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic trace_t pulse(input int e);
    return span(e, e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply pat[e] before edge e and record the outputs seen just after edge e.
  task automatic run(input int start, input int n);
    for (int e = start; e < start + n; e++) begin
      bus_a.button_in = pat[e];
      step();
      r_level[e]   = bus_a.level;
      r_press[e]   = bus_a.press_tick;
      r_release[e] = bus_a.release_tick;
      r_repeat[e]  = bus_a.repeat_tick;
      r_long[e]    = bus_a.long_press;
      r_bout[e]    = bus_a.button_out;
      b_long[e]    = bus_b.long_press;
      b_repeat[e]  = bus_b.repeat_tick;
      b_bout[e]    = bus_b.button_out;
    end
  endtask

  task automatic do_reset();
    reset_n         = 1'b0;
    bus_a.button_in = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (2) step();
    {r_level, r_press, r_release, r_repeat, r_long, r_bout} = '0;
    {b_long, b_repeat, b_bout} = '0;
    for (int e = 0; e < NREC; e++) pat[e] = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] outs;
    reset_n         = 1'b0;
    bus_a.button_in = 1'b0;
    #2;
    outs = {bus_a.level, bus_a.press_tick, bus_a.release_tick,
            bus_a.repeat_tick, bus_a.long_press, bus_a.button_out};
    checks++;
    if (outs !== 6'b0) $display("FAIL reset_outputs got %b expected %b", outs, 6'b0);
    else passed++;
    bus_a.button_in = 1'b1;
    repeat (10) step();
    outs = {bus_a.level, bus_a.press_tick, bus_a.release_tick,
            bus_a.repeat_tick, bus_a.long_press, bus_a.button_out};
    checks++;
    if (outs !== 6'b0) $display("FAIL reset_held_button got %b expected %b", outs, 6'b0);
    else passed++;
  endtask

  task automatic test_clean_press();
    do_reset();
    for (int e = 0; e < NREC; e++) pat[e] = (e < 12);
    run(0, 30);
    checks++;
    if (r_level !== span(6, 17)) $display("FAIL clean_level got %h expected %h", r_level, span(6, 17));
    else passed++;
    checks++;
    if (r_press !== pulse(6)) $display("FAIL clean_press got %h expected %h", r_press, pulse(6));
    else passed++;
    checks++;
    if (r_release !== pulse(18)) $display("FAIL clean_release got %h expected %h", r_release, pulse(18));
    else passed++;
    checks++;
    if (r_repeat !== '0) $display("FAIL clean_repeat got %h expected 0", r_repeat);
    else passed++;
    checks++;
    if (r_long !== '0) $display("FAIL clean_long got %h expected 0", r_long);
    else passed++;
    checks++;
    if (r_bout !== pulse(6)) $display("FAIL clean_button_out got %h expected %h", r_bout, pulse(6));
    else passed++;
  endtask

  task automatic test_glitch();
    do_reset();
    for (int e = 0; e < NREC; e++) pat[e] = (e < 3);
    run(0, 20);
    checks++;
    if (r_level !== '0) $display("FAIL glitch_level got %h expected 0", r_level);
    else passed++;
    checks++;
    if ((r_press | r_release | r_repeat | r_long | r_bout) !== '0)
      $display("FAIL glitch_ticks got %h expected 0", r_press | r_release | r_repeat | r_long | r_bout);
    else passed++;
  endtask

  task automatic test_bounce();
    do_reset();
    for (int e = 0; e < NREC; e++) pat[e] = (e >= 12) || (((e / 2) % 2) == 0);
    run(0, 30);
    checks++;
    if (r_press !== pulse(18)) $display("FAIL bounce_press got %h expected %h", r_press, pulse(18));
    else passed++;
    checks++;
    if (r_level !== span(18, 29)) $display("FAIL bounce_level got %h expected %h", r_level, span(18, 29));
    else passed++;
    checks++;
    if (r_release !== '0) $display("FAIL bounce_release got %h expected 0", r_release);
    else passed++;
  endtask

  task automatic test_long_hold();
    trace_t exp_rep;
    exp_rep = pulse(26) | pulse(31) | pulse(36) | pulse(41) | pulse(46);
    do_reset();
    for (int e = 0; e < NREC; e++) pat[e] = (e < 47);
    run(0, 60);
    checks++;
    if (r_level !== span(6, 52)) $display("FAIL long_level got %h expected %h", r_level, span(6, 52));
    else passed++;
    checks++;
    if (r_press !== pulse(6)) $display("FAIL long_press_tick got %h expected %h", r_press, pulse(6));
    else passed++;
    checks++;
    if (r_repeat !== exp_rep) $display("FAIL long_repeat got %h expected %h", r_repeat, exp_rep);
    else passed++;
    checks++;
    if (r_long !== span(26, 52)) $display("FAIL long_flag got %h expected %h", r_long, span(26, 52));
    else passed++;
    checks++;
    if (r_release !== pulse(53)) $display("FAIL long_release got %h expected %h", r_release, pulse(53));
    else passed++;
    checks++;
    if (r_bout !== (exp_rep | pulse(6))) $display("FAIL long_button_out got %h expected %h", r_bout, exp_rep | pulse(6));
    else passed++;
    checks++;
    if (b_long !== span(26, 52)) $display("FAIL norep_long got %h expected %h", b_long, span(26, 52));
    else passed++;
    checks++;
    if (b_repeat !== '0) $display("FAIL norep_repeat got %h expected 0", b_repeat);
    else passed++;
    checks++;
    if (b_bout !== pulse(6)) $display("FAIL norep_button_out got %h expected %h", b_bout, pulse(6));
    else passed++;
  endtask

  task automatic test_release_bounce();
    trace_t exp_rep;
    exp_rep = pulse(26) | pulse(31) | pulse(38) | pulse(43) | pulse(48);
    do_reset();
    for (int e = 0; e < NREC; e++) pat[e] = (e < 50) && (e != 33) && (e != 34);
    run(0, 64);
    checks++;
    if (r_repeat !== exp_rep) $display("FAIL dip_repeat got %h expected %h", r_repeat, exp_rep);
    else passed++;
    checks++;
    if (r_release !== pulse(56)) $display("FAIL dip_release got %h expected %h", r_release, pulse(56));
    else passed++;
    checks++;
    if (r_level !== span(6, 55)) $display("FAIL dip_level got %h expected %h", r_level, span(6, 55));
    else passed++;
    checks++;
    if (r_long !== span(26, 55)) $display("FAIL dip_long got %h expected %h", r_long, span(26, 55));
    else passed++;
  endtask

  task automatic test_reset_mid_hold();
    logic [11:0] outs;
    trace_t      exp_long;
    exp_long = span(26, 27) | span(56, 69);
    do_reset();
    for (int e = 0; e < NREC; e++) pat[e] = 1'b1;
    run(0, 28);
    reset_n = 1'b0;
    #1;
    outs = {bus_a.level, bus_a.press_tick, bus_a.release_tick, bus_a.repeat_tick,
            bus_a.long_press, bus_a.button_out,
            bus_b.level, bus_b.press_tick, bus_b.release_tick, bus_b.repeat_tick,
            bus_b.long_press, bus_b.button_out};
    checks++;
    if (outs !== 12'b0) $display("FAIL midreset_outputs got %b expected %b", outs, 12'b0);
    else passed++;
    run(28, 2);
    reset_n = 1'b1;
    run(30, 40);
    checks++;
    if (r_level !== (span(6, 27) | span(36, 69)))
      $display("FAIL midreset_level got %h expected %h", r_level, span(6, 27) | span(36, 69));
    else passed++;
    checks++;
    if (r_press !== (pulse(6) | pulse(36)))
      $display("FAIL midreset_press got %h expected %h", r_press, pulse(6) | pulse(36));
    else passed++;
    checks++;
    if (r_long !== exp_long) $display("FAIL midreset_long got %h expected %h", r_long, exp_long);
    else passed++;
    checks++;
    if (r_repeat !== (pulse(26) | pulse(56) | pulse(61) | pulse(66)))
      $display("FAIL midreset_repeat got %h expected %h", r_repeat,
               pulse(26) | pulse(56) | pulse(61) | pulse(66));
    else passed++;
    checks++;
    if (r_release !== '0) $display("FAIL midreset_release got %h expected 0", r_release);
    else passed++;
    checks++;
    if (b_long !== exp_long) $display("FAIL midreset_norep_long got %h expected %h", b_long, exp_long);
    else passed++;
    checks++;
    if (b_repeat !== '0) $display("FAIL midreset_norep_repeat got %h expected 0", b_repeat);
    else passed++;
  endtask

  initial begin
    reset_n         = 1'b0;
    bus_a.button_in = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_long_hold();
    test_release_bounce();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Per-button front-end that feeds the watch FSM's tick inputs (start/pause/lap/mode/set).
- Synchronises the raw pushbutton and debounces it.
- Emits single-cycle press/release ticks.
- Adds hold-to-repeat ticks so set-mode increment/decrement can auto-step while a button is held.
- `button_out` is a drop-in tick (press OR repeat) for the existing per-button debounce slot.

Parameters:
- `CLK_FREQ`, 100_000_000: system clock in Hz.
- `DEBOUNCE_MS`, 10: stable time required before an edge is accepted. `DB_CYCLES = (CLK_FREQ/1000)*DEBOUNCE_MS`, must be ≥1.
- `HOLD_MS`, 500: hold time before long-press/auto-repeat. `HOLD_CYCLES = (CLK_FREQ/1000)*HOLD_MS`.
- `REPEAT_MS`, 100: auto-repeat period. `REP_CYCLES = (CLK_FREQ/1000)*REPEAT_MS`.
- `REPEAT_EN`, 1: 1 = generate `repeat_tick`; 0 = never.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `button_in` in 1: raw asynchronous pushbutton, active-high.
- `level` out 1: debounced button state.
- `press_tick` out 1: one-cycle pulse on accepted press.
- `release_tick` out 1: one-cycle pulse on accepted release.
- `repeat_tick` out 1: one-cycle pulse per auto-repeat step.
- `long_press` out 1: high while held ≥ `HOLD_CYCLES`.
- `button_out` out 1: `press_tick | repeat_tick`.

Behaviour:

Reset
- While `reset_n` = 0: all outputs 0, synchroniser flops 0, all counters 0, FSM in `IDLE`.
- On reset release the button is re-evaluated from scratch. A button held through reset yields one `press_tick` after the normal debounce latency.

Synchroniser
- 2-flop chain: `sync_q` equals `button_in` delayed by 2 edges.
- Only `sync_q` is used downstream.

Debounce counter `db_cnt`
- Width: `clog2(DB_CYCLES+1)`.
- Increments each cycle `sync_q != level`; clears to 0 in any cycle `sync_q == level`.
- When `db_cnt == DB_CYCLES-1` and `sync_q != level`, `level` toggles on that edge.
- Latency: a clean input edge becomes visible on `level` exactly `DB_CYCLES+2` edges after `button_in` changes before an edge.
- Glitches shorter than `DB_CYCLES` sync-cycles produce no output.

FSM states: `IDLE`, `PRESS_DB`, `HELD`, `LONG`, `RELEASE_DB`.
- `IDLE`: `level` = 0.
  - → `PRESS_DB` when `sync_q` = 1.
- `PRESS_DB`:
  - → `IDLE` if `sync_q` = 0 before count completes.
  - → `HELD` on acceptance: `level` ← 1, `press_tick` = 1 in the first cycle `level` is 1, `hold_cnt` ← 0.
- `HELD`: `hold_cnt` increments each cycle.
  - When `hold_cnt == HOLD_CYCLES-1` → `LONG`: `long_press` ← 1; if `REPEAT_EN`, `repeat_tick` = 1 the same cycle `long_press` first reads 1; `rep_cnt` ← 0.
  - → `RELEASE_DB` when `sync_q` = 0.
- `LONG`: `rep_cnt` increments, wrapping at `REP_CYCLES-1`.
  - Each wrap issues `repeat_tick` (if `REPEAT_EN`), i.e. every `REP_CYCLES` cycles after the first.
  - → `RELEASE_DB` when `sync_q` = 0.
- `RELEASE_DB`: no `repeat_tick` issued while in this state; `hold_cnt`/`rep_cnt` frozen.
  - Returns to `HELD` or `LONG` (whichever it came from) if `sync_q` returns to 1 before count completes; counters resume.
  - On acceptance: `level` ← 0, `release_tick` = 1 in the first cycle `level` is 0, `long_press` ← 0, counters cleared → `IDLE`.

Counters and ticks
- `hold_cnt` saturates; no wrap.
- All tick outputs are registered single-cycle pulses.
- `press_tick` and `repeat_tick` are never both 1 in the same cycle (`HOLD_CYCLES` ≥ 1 guarantees ≥1 cycle gap).
- Bench parameters may scale `CLK_FREQ` so that 1 ms = 1 cycle.

Test Plan (`CLK_FREQ`=1000, `DEBOUNCE_MS`=4, `HOLD_MS`=20, `REPEAT_MS`=5, `REPEAT_EN`=1 unless stated):
1. Clean press: `button_in` 0→1 before edge 0, held 12 cycles, then 0 → `level` rises at edge 6, `press_tick` high exactly at edge 6; `release_tick` single pulse 6 edges after the fall; `long_press`/`repeat_tick` never assert.
2. Glitch: `button_in` high for 3 cycles only → `level` and all ticks stay 0 throughout.
3. Bounce: `button_in` toggles every 2 cycles for 12 cycles, then stable high → exactly one `press_tick`, 6 edges after the last toggle; no `release_tick`.
4. Long hold 45 cycles after `level` rise at edge T → `long_press` = 1 from T+20; `repeat_tick` at T+20, T+25, T+30, T+35, T+40 (5 pulses); `button_out` shows 6 pulses total; on release `long_press` drops with `release_tick`.
5. Release bounce in `LONG`: 2-cycle dip at T+27 → no `release_tick`; `repeat_tick` at T+30 is not issued; T+35 resumes only if the `rep_cnt` freeze maintains phase (bench checks the frozen-count phase: next tick at T+32).
6. Reset mid-hold: assert `reset_n`=0 at T+22 while the button stays high → all outputs 0 immediately; after release, `press_tick` recurs 6 edges later, `long_press` recurs 20 cycles after that. With `REPEAT_EN`=0: `long_press` still asserts, `repeat_tick` stays 0.
